// File: rtl/wb_pipelined_ram_slave_if.sv
// rtl/wb_pipelined_ram_slave_if.sv - pipelined Wishbone bus bundle between master and RAM slave
interface wb_pipelined_ram_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic        wb_stall_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o
  );
endinterface

// File: rtl/wb_pipelined_ram_slave.sv
// rtl/wb_pipelined_ram_slave.sv - pipelined Wishbone RAM slave with fixed latency and stall-bounded outstanding requests
module wb_pipelined_ram_slave #(
  parameter int g_num_words        = 256,
  parameter int g_latency          = 2,
  parameter int g_max_outstanding  = 4,
  parameter int g_word_granularity = 1
) (
  input  logic                           clk_sys_i,
  input  logic                           rst_i,
  wb_pipelined_ram_slave_if.slave        bus,
  output logic [3:0]                     outstanding_o
);
  localparam int         c_aw    = (g_num_words > 1) ? $clog2(g_num_words) : 1;
  localparam logic [3:0] c_max   = 4'(g_max_outstanding);
  localparam logic [31:0] c_words = 32'(g_num_words);

  logic [31:0] mem [g_num_words] = '{default: '0};

  logic [31:0]          idx;
  logic                 in_range;
  logic                 accept;
  logic                 resp;
  logic [3:0]           cnt;
  logic [g_latency-1:0] vld;
  logic [g_latency-1:0] err;
  logic [31:0]          dat [g_latency];

  always_comb begin
    idx = (g_word_granularity != 0) ? bus.wb_adr_i : {2'b00, bus.wb_adr_i[31:2]};
  end

  assign in_range = (idx < c_words);

  // Stall comes from the registered count only, so there is no input-to-stall path.
  assign bus.wb_stall_o = (cnt == c_max);
  assign accept         = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_stall_o;
  assign resp           = vld[g_latency-1];

  // RAM is deliberately outside the reset domain; committed writes survive reset.
  always_ff @(posedge clk_sys_i) begin
    if (accept && !rst_i && bus.wb_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wb_sel_i[b]) begin
          mem[idx[c_aw-1:0]][8*b +: 8] <= bus.wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      vld <= '0;
      err <= '0;
      for (int i = 0; i < g_latency; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= accept;
      err[0] <= accept & ~in_range;
      dat[0] <= (accept && in_range && !bus.wb_we_i) ? mem[idx[c_aw-1:0]] : '0;
      for (int i = 1; i < g_latency; i++) begin
        vld[i] <= vld[i-1];
        err[i] <= err[i-1];
        dat[i] <= dat[i-1];
      end
      if (!bus.wb_cyc_i) begin
        vld <= '0;
      end
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (!bus.wb_cyc_i) begin
      cnt <= '0;
    end else if (accept && !resp) begin
      cnt <= cnt + 4'd1;
    end else if (!accept && resp && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign bus.wb_ack_o   = resp & ~err[g_latency-1];
  assign bus.wb_err_o   = resp & err[g_latency-1];
  assign bus.wb_dat_o   = bus.wb_ack_o ? dat[g_latency-1] : '0;
  assign bus.wb_rty_o   = 1'b0;
  assign outstanding_o  = cnt;
endmodule
